mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, round-robin arbiter that shares the single 9-bit synchronous memory port (address, write data, write enable) between the processor and a second bus master, such as a program loader or I/O DMA. Each master uses a level request / single-cycle acknowledge handshake. The arbiter registers the winning master's address, data and write enable onto the memory, then returns read data with the acknowledge. It sits between the processor's ADDR/Dout/W outputs and the memory, and replaces their direct connection.

## Interface
- AW, default 9: memory address width.
- DW, default 9: data width.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 (processor) request; held until m0_ack.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_we  in  1  master 0 write (1) or read (0).
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_rdata  out  DW  read data; valid only while m0_ack=1.
- m1_req, m1_addr, m1_wdata, m1_we, m1_ack, m1_rdata: same as master 0, for master 1.
- mem_addr  out  AW  registered memory address.
- mem_wdata  out  DW  registered memory write data.
- mem_we  out  1  registered memory write enable.
- mem_rdata  in  DW  memory read data, one-cycle synchronous read latency.
- owner  out  1  master currently in transaction (0/1).
- busy  out  1  1 in ISSUE or RESP.

## Operation
- States:
  - IDLE: no transaction in progress.
  - ISSUE: memory is driven for exactly one cycle.
  - RESP: memory result is returned to the owner.
- Arbitration happens in IDLE and in RESP.
  - Candidates in IDLE: both masters.
  - Candidates in RESP: only the master not being acknowledged. The owner's still-high req is ignored that cycle.
  - If exactly one candidate requests, it wins.
  - If both request, the master not served last wins. `last` resets to 1, so m0 wins the first tie.
- Grant actions:
  - Register the winner's addr, wdata and we into mem_*.
  - Set owner to the winner and last to the winner.
  - Go to ISSUE.
- ISSUE → RESP unconditionally; mem_we is deasserted at this edge.
- RESP:
  - The owner's ack is 1, and its rdata = mem_rdata. For writes, rdata is don't-care.
  - Go to ISSUE if the other master wins, else IDLE.
- The non-owner's ack is always 0. The non-owner's rdata is driven to 0.
- Inputs are sampled only at the grant edge. Changes to addr/wdata/we while pending or in service are ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE, mem_addr=0, mem_wdata=0, mem_we=0, m0_ack=m1_ack=0, owner=0, last=1, busy=0.
- Reset during ISSUE aborts the access: mem_we drops at once, and no ack is ever issued for that request.
- Latency: req high in cycle C0 (IDLE) → mem_* valid in C1 → ackN=1 in C2. The memory samples at the C1→C2 edge.
- Throughput: back-to-back alternating masters get 1 access per 2 cycles. A single master repeatedly requesting gets 1 access per 3 cycles, because of the IDLE gap.
- Handshake: a master deasserts or re-presents req in the cycle after ack. Keeping req high after ack issues a new request.
- mem_we is high for exactly one cycle per write and never outside ISSUE.
- A req raised in the ISSUE cycle is not evaluated until RESP (other master) or IDLE.

## Structure
- Shared package `bus_pkg`:
  - typedef `arb_state_t` {IDLE, ISSUE, RESP};
  - localparams for default AW/DW = 9, matching the processor's 9-bit bus.
- One sub-module is natural: `rr_pick2`, a combinational two-way round-robin picker.
  - Inputs: req[1:0], mask[1:0], last.
  - Outputs: valid, winner.
- All state and mem_* outputs live in mem_arbiter's single always_ff with asynchronous rst.

## Test plan
- **Reset:** assert rst mid-ISSUE of a write (m0, addr 0x05, data 0x1AA) → mem_we=0 immediately, no m0_ack, and after release a fresh m0 read of 0x05 returns prior contents.
- **Single read:** preload mem[0x10]=0x0F3; m0 reads 0x10 → mem_addr=0x10 in C1, m0_ack=1 with m0_rdata=0x0F3 in C2, m1_ack=0.
- **Tie at reset:** m0 and m1 both request in the same cycle → m0 served first, then m1 in ISSUE the cycle right after m0's ack (owner 0→1, acks two cycles apart).
- **Fairness:** m0 and m1 hold req continuously for 8 transactions → grants strictly alternate 0,1,0,1…, and each master gets 4 acks.
- **Write-then-read:** m1 writes 0x155 to 0x1FF, then m0 reads 0x1FF → m0_rdata=0x155, and mem_we was high for exactly one cycle.
- **Ignore rule:** m0 alone keeps req high → successive acks spaced 3 cycles apart, and no ack without an ISSUE cycle preceding it.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the processor's 9-bit memory bus.
//   arb_state_t : arbiter sequencing states
//   BUS_AW/BUS_DW : default address and data widths of the processor bus
package bus_pkg;

   localparam int unsigned BUS_AW = 9;
   localparam int unsigned BUS_DW = 9;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
//   req    : request lines of master 0 (bit 0) and master 1 (bit 1)
//   mask   : which requests are eligible this cycle
//   last   : master served most recently
//   valid  : at least one eligible request
//   winner : selected master (meaningful only when valid)
module rr_pick2 (
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       last,
   output logic       valid,
   output logic       winner
);

   logic [1:0] cand;

   assign cand  = req & mask;
   assign valid = |cand;
   // On a tie the master not served last wins; otherwise the lone candidate.
   assign winner = (cand == 2'b11) ? ~last : cand[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single synchronous memory port.
//   clk, rst                 : clock and asynchronous active-high reset
//   mN_req/addr/wdata/we     : master N request (level, held until mN_ack)
//   mN_ack                   : one-cycle completion pulse to master N
//   mN_rdata                 : read data, mem_rdata while mN_ack, else 0
//   mem_addr/wdata/we        : registered memory command (valid in ISSUE)
//   mem_rdata                : memory read data, one cycle after the command
//   owner                    : master currently in transaction
//   busy                     : high while in ISSUE or RESP
module mem_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned AW = BUS_AW,
   parameter int unsigned DW = BUS_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_we,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_we,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner,
   output logic          busy
);

   arb_state_t state;
   logic       last;
   logic [1:0] mask;
   logic       pick_valid;
   logic       pick_winner;

   // In RESP only the master not being acknowledged may compete, so the
   // owner's still-high request cannot be granted twice for one transaction.
   always_comb begin
      mask = 2'b00;
      case (state)
         IDLE:    mask = 2'b11;
         RESP:    mask = owner ? 2'b01 : 2'b10;
         default: mask = 2'b00;
      endcase
   end

   rr_pick2 u_pick (
      .req    ({m1_req, m0_req}),
      .mask   (mask),
      .last   (last),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         owner     <= 1'b0;
         last      <= 1'b1;
         busy      <= 1'b0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         case (state)
            IDLE, RESP: begin
               mem_we <= 1'b0;
               if (pick_valid) begin
                  mem_addr  <= pick_winner ? m1_addr  : m0_addr;
                  mem_wdata <= pick_winner ? m1_wdata : m0_wdata;
                  mem_we    <= pick_winner ? m1_we    : m0_we;
                  owner     <= pick_winner;
                  last      <= pick_winner;
                  state     <= ISSUE;
                  busy      <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            ISSUE: begin
               // Memory samples the command at this edge; result arrives in RESP.
               mem_we <= 1'b0;
               m0_ack <= ~owner;
               m1_ack <= owner;
               state  <= RESP;
               busy   <= 1'b1;
            end
            default: begin
               mem_we <= 1'b0;
               state  <= IDLE;
               busy   <= 1'b0;
            end
         endcase
      end
   end

   assign m0_rdata = m0_ack ? mem_rdata : '0;
   assign m1_rdata = m1_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed latency/reset/tie cases plus
// randomized two-master traffic checked by a per-master scoreboard against a
// reference memory image.
module tb_mem_arbiter;
   import bus_pkg::*;

   localparam int AW = BUS_AW;
   localparam int DW = BUS_DW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          m0_req = 1'b0, m1_req = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_we = 1'b0, m1_we = 1'b0;
   logic          m0_ack, m1_ack;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata = '0;
   logic          owner, busy;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_we     (m0_we),
      .m0_ack    (m0_ack),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_we     (m1_we),
      .m1_ack    (m1_ack),
      .m1_rdata  (m1_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .owner     (owner),
      .busy      (busy)
   );

   // Synchronous memory: read-before-write, one-cycle read latency.
   logic [DW-1:0] mem  [1 << AW];
   logic [DW-1:0] refm [1 << AW];

   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] = mem_wdata;
   end

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] rdata;
   } exp_t;

   typedef struct {
      int cyc;
      int m;
   } ack_t;

   exp_t q0[$];
   exp_t q1[$];
   ack_t ack_log[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int we_cycles = 0;
   int wr_acks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present a request and queue the expected response from the reference image.
   task automatic present(input int m, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd);
      exp_t e;
      e.we    = we;
      e.addr  = addr;
      e.rdata = refm[addr];
      if (we) refm[addr] = wd;
      if (m == 0) begin
         m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
         q0.push_back(e);
      end else begin
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
         q1.push_back(e);
      end
   endtask

   task automatic set_req(input int m, input logic v);
      if (m == 0) m0_req = v;
      else        m1_req = v;
   endtask

   task automatic wait_ack(input int m, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((m == 0) ? m0_ack : m1_ack) begin
            ok = 1'b1;
            return;
         end
      end
      check($sformatf("ack_timeout_m%0d", m), 0, 1);
   endtask

   // n random transactions in this master's half of the address space.
   task automatic drive(input int m, input int n, input int max_gap);
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      bit            ok;
      int            gap;
      for (int i = 0; i < n; i++) begin
         we         = 1'($urandom_range(0, 1));
         addr       = AW'($urandom);
         addr[AW-1] = 1'(m);
         wd         = DW'($urandom);
         present(m, we, addr, wd);
         wait_ack(m, ok);
         @(posedge clk); #1;
         if (!ok) begin
            set_req(m, 1'b0);
            return;
         end
         gap = $urandom_range(0, max_gap);
         if (gap > 0 || i == n - 1) begin
            set_req(m, 1'b0);
            for (int g = 0; g < gap; g++) begin
               @(posedge clk); #1;
            end
         end
      end
   endtask

   // One isolated transaction with cycle-exact latency checks; starts in IDLE.
   task automatic single(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic we);
      present(m, we, addr, wd);
      @(posedge clk); #1;
      check("c1_busy", int'(busy), 1);
      check("c1_owner", int'(owner), m);
      check("c1_addr", int'(mem_addr), int'(addr));
      check("c1_we", int'(mem_we), int'(we));
      check("c1_no_ack", int'(m0_ack | m1_ack), 0);
      if (we) check("c1_wdata", int'(mem_wdata), int'(wd));
      @(posedge clk); #1;
      check("c2_ack", int'((m == 0) ? m0_ack : m1_ack), 1);
      check("c2_other_ack", int'((m == 0) ? m1_ack : m0_ack), 0);
      check("c2_we_low", int'(mem_we), 0);
      @(posedge clk); #1;
      set_req(m, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Monitor: pops the owner's scoreboard on every ack.
   initial begin : monitor
      exp_t e;
      int   m;
      logic prev_issue;
      logic prev_we;
      prev_issue = 1'b0;
      prev_we    = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_issue = 1'b0;
            prev_we    = 1'b0;
            continue;
         end
         if (m0_ack && m1_ack) check("dual_ack", 1, 0);
         if (m0_ack || m1_ack) begin
            m = m1_ack ? 1 : 0;
            check("ack_owner", int'(owner), m);
            check("ack_after_issue", int'(prev_issue), 1);
            check("other_rdata_zero", int'((m == 0) ? m1_rdata : m0_rdata), 0);
            ack_log.push_back('{cyc, m});
            if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
               check($sformatf("unexpected_ack_m%0d", m), 1, 0);
            end else begin
               if (m == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               if (e.we) wr_acks++;
               else check($sformatf("rdata_m%0d_%03h", m, e.addr),
                          int'((m == 0) ? m0_rdata : m1_rdata), int'(e.rdata));
            end
         end
         if (mem_we) begin
            we_cycles++;
            check("we_single_cycle", int'(prev_we), 0);
            check("we_in_issue", int'(busy && !m0_ack && !m1_ack), 1);
         end
         prev_we    = mem_we;
         prev_issue = busy && !m0_ack && !m1_ack;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int we_before;
      int n0;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]  = DW'($urandom);
         refm[i] = mem[i];
      end

      // Reset values.
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_we", int'(mem_we), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      check("rst_mem_wdata", int'(mem_wdata), 0);
      check("rst_acks", int'(m0_ack | m1_ack), 0);
      check("rst_owner", int'(owner), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset during ISSUE of a write aborts it; not queued, so any ack is flagged.
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'h005; m0_wdata = 9'h1AA;
      @(posedge clk); #1;
      check("abort_we_before", int'(mem_we), 1);
      #2 rst = 1'b1;
      #1;
      check("abort_we_now", int'(mem_we), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_ack", int'(m0_ack), 0);
      m0_req = 1'b0; m0_we = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_no_ack", int'(m0_ack), 0);
      end
      @(posedge clk); #1;
      single(0, 9'h005, 9'h000, 1'b0);

      // Single read with known contents.
      mem[9'h010]  = 9'h0F3;
      refm[9'h010] = 9'h0F3;
      single(0, 9'h010, 9'h000, 1'b0);

      // Tie straight after reset: m0 first, m1 issued right after m0's ack.
      do_reset();
      present(0, 1'b0, 9'h020, 9'h000);
      present(1, 1'b0, 9'h120, 9'h000);
      @(posedge clk); #1;
      check("tie_c1_owner", int'(owner), 0);
      check("tie_c1_addr", int'(mem_addr), 'h020);
      @(posedge clk); #1;
      check("tie_c2_m0_ack", int'(m0_ack), 1);
      check("tie_c2_m1_ack", int'(m1_ack), 0);
      @(posedge clk); #1;
      m0_req = 1'b0;
      check("tie_c3_owner", int'(owner), 1);
      check("tie_c3_addr", int'(mem_addr), 'h120);
      check("tie_c3_busy", int'(busy), 1);
      check("tie_c3_noack", int'(m0_ack | m1_ack), 0);
      @(posedge clk); #1;
      check("tie_c4_m1_ack", int'(m1_ack), 1);
      check("tie_c4_m0_ack", int'(m0_ack), 0);
      @(posedge clk); #1;
      m1_req = 1'b0;
      @(posedge clk); #1;

      // Fairness: both hold req for 4 transactions each; m1 was served last.
      ack_log.delete();
      fork
         drive(0, 4, 0);
         drive(1, 4, 0);
      join
      check("fair_acks", ack_log.size(), 8);
      n0 = 0;
      foreach (ack_log[i]) begin
         if (ack_log[i].m == 0) n0++;
         check($sformatf("fair_order_%0d", i), ack_log[i].m, i % 2);
         if (i > 0) check($sformatf("fair_spacing_%0d", i), ack_log[i].cyc - ack_log[i-1].cyc, 2);
      end
      check("fair_m0_count", n0, 4);
      @(posedge clk); #1;

      // Write from m1, then read back from m0.
      we_before = we_cycles;
      single(1, 9'h1FF, 9'h155, 1'b1);
      single(0, 9'h1FF, 9'h000, 1'b0);
      check("wtr_we_cycles", we_cycles - we_before, 1);

      // Lone master holding req: owner's req is ignored in RESP, so 3-cycle spacing.
      ack_log.delete();
      drive(0, 4, 0);
      check("ign_acks", ack_log.size(), 4);
      foreach (ack_log[i]) begin
         if (i > 0) check($sformatf("ign_spacing_%0d", i), ack_log[i].cyc - ack_log[i-1].cyc, 3);
      end
      @(posedge clk); #1;

      // Random mixed traffic.
      fork
         drive(0, 20, 3);
         drive(1, 20, 3);
      join
      repeat (3) @(posedge clk);
      #1;
      check("end_q0_empty", q0.size(), 0);
      check("end_q1_empty", q1.size(), 0);
      check("end_we_vs_writes", we_cycles, wr_acks);
      check("end_idle", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
